// File: rtl/am_dc_tracker.sv
// am_dc_tracker: windowed DC estimator (peak midpoint or mean) for a signed AM
// demodulator stream, with saturating DC subtraction on the sample path.
module am_dc_tracker #(
  parameter int unsigned DW       = 14,
  parameter int unsigned WIN_LOG2 = 12,
  parameter int unsigned THRESH   = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  input  logic          start,
  input  logic          auto_en,
  input  logic          mode,
  output logic [DW-1:0] dout,
  output logic          out_valid,
  output logic [DW-1:0] dc_est,
  output logic          dc_valid,
  output logic          const_flag,
  output logic          busy
);

  localparam int unsigned SW = DW + WIN_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_CALC = 2'd2
  } state_t;

  state_t                state_q;
  logic [WIN_LOG2-1:0]   cnt_q;
  logic [SW-1:0]         sum_q;
  logic [DW-1:0]         max_q;
  logic [DW-1:0]         min_q;
  logic                  first_q;
  logic                  mode_q;
  logic [DW-1:0]         dc_est_q;
  logic                  dc_valid_q;
  logic                  const_q;
  logic                  busy_q;
  logic [DW-1:0]         dout_q;
  logic                  out_valid_q;

  logic [DW:0]           diff_c;
  logic [DW-1:0]         sat_c;
  logic [DW:0]           mm_sum_c;
  logic [DW:0]           p2p_c;
  logic                  const_c;
  logic [DW-1:0]         dc_calc_c;
  logic [SW-1:0]         din_sx_c;
  logic                  gt_max_c;
  logic                  lt_min_c;
  logic                  last_c;

  // Window arithmetic and saturating subtraction, all in widened signed form
  always_comb begin
    diff_c    = {din[DW-1], din} - {dc_est_q[DW-1], dc_est_q};
    sat_c     = diff_c[DW-1:0];
    if (diff_c[DW] != diff_c[DW-1]) begin
      sat_c = diff_c[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    mm_sum_c  = {max_q[DW-1], max_q} + {min_q[DW-1], min_q};
    p2p_c     = {max_q[DW-1], max_q} - {min_q[DW-1], min_q};
    const_c   = $signed(p2p_c) < $signed((DW+1)'(THRESH));
    dc_calc_c = mode_q ? sum_q[SW-1:WIN_LOG2] : mm_sum_c[DW:1];
    din_sx_c  = {{WIN_LOG2{din[DW-1]}}, din};
    gt_max_c  = $signed(din) > $signed(max_q);
    lt_min_c  = $signed(din) < $signed(min_q);
    last_c    = (cnt_q == {WIN_LOG2{1'b1}});
  end

  // Measurement FSM: window accumulation, estimate commit and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      min_q      <= '0;
      first_q    <= 1'b0;
      mode_q     <= 1'b0;
      dc_est_q   <= '0;
      dc_valid_q <= 1'b0;
      const_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dc_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_MEAS;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= '0;
            first_q <= 1'b1;
            mode_q  <= mode;
          end
        end
        S_MEAS: begin
          if (start) begin
            // abort: discard the partial window and begin again
            cnt_q   <= '0;
            sum_q   <= '0;
            first_q <= 1'b1;
            mode_q  <= mode;
          end else if (in_valid) begin
            sum_q   <= sum_q + din_sx_c;
            cnt_q   <= cnt_q + WIN_LOG2'(1);
            first_q <= 1'b0;
            if (first_q || gt_max_c) max_q <= din;
            if (first_q || lt_min_c) min_q <= din;
            if (last_c) state_q <= S_CALC;
          end
        end
        S_CALC: begin
          dc_est_q   <= dc_calc_c;
          const_q    <= const_c;
          dc_valid_q <= 1'b1;
          if (start || auto_en) begin
            state_q <= S_MEAS;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= '0;
            first_q <= 1'b1;
            mode_q  <= mode;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sample path: one-cycle registered din - dc_est, independent of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dout_q      <= sat_c;
      out_valid_q <= in_valid;
    end
  end

  assign dout       = dout_q;
  assign out_valid  = out_valid_q;
  assign dc_est     = dc_est_q;
  assign dc_valid   = dc_valid_q;
  assign const_flag = const_q;
  assign busy       = busy_q;

endmodule
